// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU-side SRAM arbiter: owner encoding and
// the timing constants that the arbiter is built around.
package cpu_pkg;

    // Which requester owns the access currently in flight.
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    // Default bound on consecutive data grants while fetch waits.
    localparam int STARVE_MAX_DEF = 4;

    // Width of the starvation counter; holds values up to 15.
    localparam int STARVE_W = 4;

    // The unified SRAM returns read data one cycle after sram_en.
    localparam int SRAM_RD_LAT = 1;

endpackage

// File: rtl/sram_arb_prio.sv
// Combinational grant picker: data wins by default, fetch wins when the
// starvation flag is raised. Grants are one-hot or all-zero.
module sram_arb_prio (
    input  logic inst_req,
    input  logic data_req,
    input  logic starve,
    output logic gnt_inst,
    output logic gnt_data
);

    // Pick the winner for this cycle.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (inst_req && data_req) begin
            if (starve) begin
                gnt_inst = 1'b1;
            end else begin
                gnt_data = 1'b1;
            end
        end else if (inst_req) begin
            gnt_inst = 1'b1;
        end else if (data_req) begin
            gnt_data = 1'b1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Shares a single-port, 1-cycle-latency SRAM between instruction fetch and
// data access. Grants are combinational (0-cycle addr_ok); data_ok follows
// one cycle later. A starvation counter forces a fetch grant after
// STARVE_MAX consecutive data grants while fetch is waiting.
module sram_arbiter
    import cpu_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [STARVE_W-1:0] STARVE_MAX_C = STARVE_W'(STARVE_MAX);

    // Reset-release synchroniser; bit 1 is the "arbiter may grant" flag.
    logic [1:0]          rst_sync_q, rst_sync_d;
    logic                arb_rdy;

    logic                resp_valid_q, resp_valid_d;
    owner_e              resp_owner_q, resp_owner_d;
    logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

    logic                starve;
    logic                gnt_inst, gnt_data;

    assign arb_rdy = rst_sync_q[1];
    assign starve  = (starve_cnt_q == STARVE_MAX_C);

    // Requests are masked until reset release has been synchronised, so no
    // handshake or SRAM strobe can leak out while resetn is low.
    sram_arb_prio u_prio (
        .inst_req (inst_req & arb_rdy),
        .data_req (data_req & arb_rdy),
        .starve   (starve),
        .gnt_inst (gnt_inst),
        .gnt_data (gnt_data)
    );

    // Grant-cycle outputs: handshakes and the SRAM command from the winner.
    always_comb begin
        inst_addr_ok = gnt_inst;
        data_addr_ok = gnt_data;
        sram_en      = gnt_inst | gnt_data;
        sram_we      = 4'b0000;
        sram_addr    = '0;
        sram_wdata   = '0;
        if (gnt_data) begin
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
            if (data_wr) begin
                sram_we = data_wstrb;
            end
        end else if (gnt_inst) begin
            sram_addr  = inst_addr;
            sram_wdata = data_wdata;
        end
    end

    // Response routing: SRAM read data goes to both ports, data_ok picks one.
    always_comb begin
        inst_data_ok = arb_rdy & resp_valid_q & (resp_owner_q == OWN_INST);
        data_data_ok = arb_rdy & resp_valid_q & (resp_owner_q == OWN_DATA);
        inst_rdata   = sram_rdata;
        data_rdata   = sram_rdata;
    end

    // Next state for the synchroniser, response tracker and starve counter.
    always_comb begin
        rst_sync_d   = {rst_sync_q[0], 1'b1};
        resp_valid_d = sram_en;
        resp_owner_d = resp_owner_q;
        starve_cnt_d = starve_cnt_q;

        if (gnt_data) begin
            resp_owner_d = OWN_DATA;
        end else if (gnt_inst) begin
            resp_owner_d = OWN_INST;
        end

        // The counter only measures an unbroken wait by fetch.
        if (!inst_req || gnt_inst) begin
            starve_cnt_d = '0;
        end else if (gnt_data && (starve_cnt_q != STARVE_MAX_C)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q   <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_owner_q <= OWN_INST;
            starve_cnt_q <= '0;
        end else begin
            rst_sync_q   <= rst_sync_d;
            resp_valid_q <= resp_valid_d;
            resp_owner_q <= resp_owner_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
